// File: rtl/conv_acc_quant.sv
// conv_acc_quant: accumulates N adder-tree partial sums into one output pixel,
// adds the per-channel bias, applies a rounding arithmetic right shift, optional
// ReLU, and saturates to a signed OUT_W activation.
// Pipeline: accumulate -> bias -> round-add -> shift -> activate/saturate.
// vld_o fires 4 edges after the edge that accepts a group's last partial.
module conv_acc_quant #(
  parameter int IN_W   = 21,
  parameter int ACC_W  = 25,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vld_i,
  input  logic [IN_W-1:0]   acc_i,
  input  logic [3:0]        grp_num_i,
  input  logic [BIAS_W-1:0] bias_i,
  input  logic [3:0]        shift_i,
  input  logic              relu_en_i,
  input  logic              clr_i,
  output logic [OUT_W-1:0]  data_o,
  output logic              vld_o,
  output logic              busy_o
);

  localparam int SUM_W = ACC_W + 1;
  localparam int RND_W = ACC_W + 2;
  localparam logic signed [RND_W-1:0] SAT_HI = RND_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RND_W-1:0] SAT_LO = RND_W'(-(2 ** (OUT_W - 1)));

  // stage 1: group counter, accumulator, config captured with the last partial
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        gnm_q, gnm_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              last_q, last_d;
  logic [BIAS_W-1:0] bias1_q, bias1_d;
  logic [3:0]        shift1_q, shift1_d;
  logic              relu1_q, relu1_d;
  // stages 2..4: datapath and the config that travels with it
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [RND_W-1:0]        rnd_q, rnd_d;
  logic signed [RND_W-1:0] sh_q, sh_d;
  logic [3:0]              shift2_q, shift3_q;
  logic                    relu2_q, relu3_q, relu4_q;
  logic [OUT_W-1:0]        data_q, data_d;
  logic [3:0]              vld_pipe_q, vld_pipe_d;

  logic [ACC_W-1:0] acc_in;
  logic [3:0]       grp_eff;
  logic [RND_W-1:0] rnd_off;
  logic [OUT_W-1:0] res;

  assign acc_in  = {{(ACC_W-IN_W){acc_i[IN_W-1]}}, acc_i};
  // group size is taken from the port only on the first partial of a group
  assign grp_eff = (cnt_q == 4'd0) ? grp_num_i : gnm_q;

  // stage 1 next-state: clr aborts the group and swallows a coincident vld_i
  always_comb begin
    cnt_d    = cnt_q;
    gnm_d    = gnm_q;
    acc_d    = acc_q;
    last_d   = 1'b0;
    bias1_d  = bias1_q;
    shift1_d = shift1_q;
    relu1_d  = relu1_q;
    if (clr_i) begin
      cnt_d = 4'd0;
      acc_d = '0;
    end else if (vld_i) begin
      if (cnt_q == 4'd0) begin
        acc_d = acc_in;
        gnm_d = grp_num_i;
      end else begin
        acc_d = acc_q + acc_in;
      end
      if (cnt_q == grp_eff) begin
        cnt_d    = 4'd0;
        last_d   = 1'b1;
        bias1_d  = bias_i;
        shift1_d = shift_i;
        relu1_d  = relu_en_i;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // stages 2..4 datapath: bias add, round offset, arithmetic shift, saturate
  always_comb begin
    sum_d   = {acc_q[ACC_W-1], acc_q} +
              {{(SUM_W-BIAS_W){bias1_q[BIAS_W-1]}}, bias1_q};
    rnd_off = '0;
    if (shift2_q != 4'd0)
      rnd_off = {{(RND_W-1){1'b0}}, 1'b1} << (shift2_q - 4'd1);
    rnd_d   = {sum_q[SUM_W-1], sum_q} + rnd_off;
    sh_d    = $signed(rnd_q) >>> shift3_q;
    if (relu4_q && sh_q[RND_W-1])
      res = '0;
    else if (sh_q > SAT_HI)
      res = SAT_HI[OUT_W-1:0];
    else if (sh_q < SAT_LO)
      res = SAT_LO[OUT_W-1:0];
    else
      res = sh_q[OUT_W-1:0];
    data_d     = vld_pipe_q[2] ? res : data_q;
    vld_pipe_d = {vld_pipe_q[2:0], last_q};
  end

  // all pipeline state; reset discards every in-flight group
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      gnm_q      <= '0;
      acc_q      <= '0;
      last_q     <= 1'b0;
      bias1_q    <= '0;
      shift1_q   <= '0;
      relu1_q    <= 1'b0;
      sum_q      <= '0;
      rnd_q      <= '0;
      sh_q       <= '0;
      shift2_q   <= '0;
      shift3_q   <= '0;
      relu2_q    <= 1'b0;
      relu3_q    <= 1'b0;
      relu4_q    <= 1'b0;
      data_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      gnm_q      <= gnm_d;
      acc_q      <= acc_d;
      last_q     <= last_d;
      bias1_q    <= bias1_d;
      shift1_q   <= shift1_d;
      relu1_q    <= relu1_d;
      sum_q      <= sum_d;
      rnd_q      <= rnd_d;
      sh_q       <= sh_d;
      shift2_q   <= shift1_q;
      shift3_q   <= shift2_q;
      relu2_q    <= relu1_q;
      relu3_q    <= relu2_q;
      relu4_q    <= relu3_q;
      data_q     <= data_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_pipe_q[3];
  assign busy_o = (cnt_q != 4'd0);

endmodule

// File: tb/tb_conv_acc_quant.sv
// Directed bench for conv_acc_quant: hand-computed vectors, immediate assertions.
module tb_conv_acc_quant;
  logic        clk = 1'b0;
  logic        rstn;
  logic        vld_i;
  logic [20:0] acc_i;
  logic [3:0]  grp_num_i;
  logic [15:0] bias_i;
  logic [3:0]  shift_i;
  logic        relu_en_i;
  logic        clr_i;
  logic [7:0]  data_o;
  logic        vld_o;
  logic        busy_o;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  conv_acc_quant dut (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .acc_i(acc_i), .grp_num_i(grp_num_i),
    .bias_i(bias_i), .shift_i(shift_i), .relu_en_i(relu_en_i), .clr_i(clr_i),
    .data_o(data_o), .vld_o(vld_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int a);
    vld_i = 1'b1;
    acc_i = a[20:0];
    tick();
    vld_i = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] g, input logic [15:0] b, input logic [3:0] s,
                     input logic r);
    grp_num_i = g;
    bias_i    = b;
    shift_i   = s;
    relu_en_i = r;
  endtask

  // called right after the last partial is accepted: result must appear on the 4th edge
  task automatic expect_out(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_early"}, 32'(vld_o), 32'd0);
    end
    tick();
    chk({tag, "_vld"}, 32'(vld_o), 32'd1);
    chk({tag, "_data"}, 32'(data_o), 32'(exp));
    tick();
    chk({tag, "_pulse"}, 32'(vld_o), 32'd0);
    chk({tag, "_hold"}, 32'(data_o), 32'(exp));
  endtask

  initial begin
    rstn = 1'b0; vld_i = 1'b0; acc_i = '0; clr_i = 1'b0;
    cfg(4'd0, 16'd0, 4'd0, 1'b0);
    tick(); tick();
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_vld", 32'(vld_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rstn = 1'b1;
    tick();

    // N=1 pass-through
    push(100);
    expect_out("n1_pos", 8'd100);
    push(-7);
    expect_out("n1_neg", 8'hF9);

    // N=3 with a gap, bias 12, shift 5: (2512+16)>>>5 = 79
    cfg(4'd2, 16'd12, 4'd5, 1'b0);
    push(1000);
    chk("g3_busy1", 32'(busy_o), 32'd1);
    tick(); tick(); tick();
    chk("g3_busy_gap", 32'(busy_o), 32'd1);
    push(2000);
    chk("g3_busy2", 32'(busy_o), 32'd1);
    push(-500);
    chk("g3_busy_end", 32'(busy_o), 32'd0);
    expect_out("g3", 8'd79);

    // saturation and ReLU, shift 4
    cfg(4'd0, 16'd0, 4'd4, 1'b0);
    push(100000);
    expect_out("sat_hi", 8'd127);
    push(-100000);
    expect_out("sat_lo", 8'h80);
    relu_en_i = 1'b1;
    push(-100000);
    expect_out("relu", 8'd0);

    // 16 x 0x0FFFFF + 32767 must not wrap
    cfg(4'd15, 16'd32767, 4'd0, 1'b0);
    for (int i = 0; i < 15; i++) push(32'h000F_FFFF);
    chk("ext_busy", 32'(busy_o), 32'd1);
    push(32'h000F_FFFF);
    chk("ext_busy_end", 32'(busy_o), 32'd0);
    expect_out("extreme", 8'd127);

    // rounding half-up
    cfg(4'd0, 16'd0, 4'd1, 1'b0);
    push(5);      expect_out("rnd_5", 8'd3);
    push(-3);     expect_out("rnd_m3", 8'hFF);
    push(-5);     expect_out("rnd_m5", 8'hFE);
    push(4);      expect_out("rnd_4", 8'd2);
    shift_i = 4'd15;
    push(16384);  expect_out("rnd15_hi", 8'd1);
    push(16383);  expect_out("rnd15_lo", 8'd0);

    // full-rate streaming, N=2, bias switches to 100 from the 3rd group
    cfg(4'd1, 16'd0, 4'd0, 1'b0);
    push(1); push(2); push(3); push(4);
    bias_i = 16'd100;
    push(5);
    push(6);
    chk("st_v1", 32'(vld_o), 32'd1);
    chk("st_d1", 32'(data_o), 32'd3);
    push(7);
    chk("st_gap1", 32'(vld_o), 32'd0);
    push(8);
    chk("st_v2", 32'(vld_o), 32'd1);
    chk("st_d2", 32'(data_o), 32'd7);
    tick();
    chk("st_gap2", 32'(vld_o), 32'd0);
    tick();
    chk("st_v3", 32'(vld_o), 32'd1);
    chk("st_d3", 32'(data_o), 32'd111);
    tick(); tick();
    chk("st_v4", 32'(vld_o), 32'd1);
    chk("st_d4", 32'(data_o), 32'd115);
    tick(); tick();

    // abort: clr wins over a coincident partial
    cfg(4'd2, 16'd0, 4'd0, 1'b0);
    push(50);
    push(60);
    chk("clr_busy_pre", 32'(busy_o), 32'd1);
    vld_i = 1'b1; acc_i = 21'd999; clr_i = 1'b1;
    tick();
    vld_i = 1'b0; clr_i = 1'b0;
    chk("clr_busy_post", 32'(busy_o), 32'd0);
    push(10);
    push(10);
    push(10);
    expect_out("clr", 8'd30);

    // reset 2 cycles after a last partial, with a new group half-accumulated
    cfg(4'd0, 16'd0, 4'd0, 1'b0);
    push(5);
    grp_num_i = 4'd1;
    push(3);
    chk("mr_busy_pre", 32'(busy_o), 32'd1);
    tick();
    rstn = 1'b0;
    #1;
    chk("mr_data", 32'(data_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_vld", 32'(vld_o), 32'd0);
    tick(); tick();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mr_no_out", 32'(vld_o), 32'd0);
    end
    chk("mr_data_end", 32'(data_o), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
